// File: rtl/ralu_microseq.sv
// Microprogram sequencer driving the register-ALU control inputs from a writable store.
// Define RALU_MICROSEQ_WDOG_EN to enable the MAX_STEPS watchdog abort.
module ralu_microseq #(
  parameter int AW        = 4,
  parameter int MAX_STEPS = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15+AW:0] prog_data,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic          P4,
  output logic [3:0]    S,
  output logic          M,
  output logic          P0,
  output logic          A,
  output logic [2:0]    v,
  output logic [2:0]    adr,
  output logic          wr,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

  localparam logic [1:0] OP_JMP  = 2'b01;
  localparam logic [1:0] OP_JC   = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  state_t         state;
  logic [15+AW:0] store [2**AW];
  logic [15+AW:0] word;
  logic [13:0]    ctl;
  logic [1:0]     op;
  logic [AW-1:0]  target;
  logic [AW-1:0]  pc_inc;
  logic [AW-1:0]  pc_next;
  logic           carry;
  logic           halt_now;
  logic           wr_mask;

  // The store is never reset so a program survives a sequencer reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && prog_we)
      store[prog_addr] <= prog_data;
  end

  assign word   = store[pc];
  assign pc_inc = pc + AW'(1);
  assign {wr, adr, v, A, P0, M, S} = ctl;

  always_comb begin
    pc_next = pc_inc;
    case (op)
      OP_JMP:  pc_next = target;
      OP_JC:   if (carry) pc_next = target;
      default: pc_next = pc_inc;
    endcase
  end

`ifdef RALU_MICROSEQ_WDOG_EN
  localparam int SW = $clog2(MAX_STEPS + 1);

  logic [SW-1:0] steps;
  logic          wd_hit;
  logic          err_q;

  // Trips on the fetch of the MAX_STEPS-th instruction unless that one halts anyway.
  assign wr_mask  = (steps == SW'(MAX_STEPS - 1)) && (word[15:14] != OP_HALT);
  assign halt_now = (op == OP_HALT) || wd_hit;
  assign err      = err_q;
`else
  assign wr_mask  = 1'b0;
  assign halt_now = (op == OP_HALT);
  assign err      = (MAX_STEPS < 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      pc     <= '0;
      ctl    <= '0;
      op     <= '0;
      target <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef RALU_MICROSEQ_WDOG_EN
      steps  <= '0;
      wd_hit <= 1'b0;
      err_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            pc    <= start_addr;
            carry <= 1'b0;
            busy  <= 1'b1;
            state <= FETCH;
`ifdef RALU_MICROSEQ_WDOG_EN
            steps <= '0;
            err_q <= 1'b0;
`endif
          end
        end
        FETCH: begin
          ctl    <= {word[13] & ~wr_mask, word[12:0]};
          op     <= word[15:14];
          target <= word[15+AW:16];
          state  <= EXEC;
`ifdef RALU_MICROSEQ_WDOG_EN
          wd_hit <= wr_mask;
`endif
        end
        EXEC: begin
          ctl   <= '0;
          carry <= P4;
`ifdef RALU_MICROSEQ_WDOG_EN
          steps <= steps + SW'(1);
          if (wd_hit) err_q <= 1'b1;
`endif
          if (halt_now) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            pc    <= pc_next;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ralu_microseq.sv
// Scoreboard bench for ralu_microseq: an instruction-level model predicts the per-cycle trace,
// a monitor compares it against the sequencer outputs. Honours RALU_MICROSEQ_WDOG_EN.
module tb_ralu_microseq;

  localparam int AW    = 4;
  localparam int WD    = 4;
  localparam int LIMIT = 10;

  localparam logic [1:0] OP_NEXT = 2'b00;
  localparam logic [1:0] OP_JMP  = 2'b01;
  localparam logic [1:0] OP_JC   = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

`ifdef RALU_MICROSEQ_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [15+AW:0] prog_data = '0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          P4 = 1'b0;
  logic [3:0]    S;
  logic          M, P0, A, wr, busy, done, err;
  logic [2:0]    v, adr;
  logic [AW-1:0] pc;

  always #5 clk = ~clk;

  ralu_microseq #(.AW(AW), .MAX_STEPS(WD)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .start_addr(start_addr), .P4(P4),
    .S(S), .M(M), .P0(P0), .A(A), .v(v), .adr(adr), .wr(wr),
    .pc(pc), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [20:0] obs;
    bit          chk_pc;
  } exp_t;

  exp_t           expq[$];
  logic [15+AW:0] model_mem [16];
  bit             model_err;
  int             checks = 0;
  int             errors = 0;
  int             sample_no = 0;

  function automatic logic [15+AW:0] mk(input logic [1:0] op, input logic [AW-1:0] tgt,
                                        input logic w, input logic [2:0] ad, input logic [2:0] vv,
                                        input logic aa, input logic p0, input logic mm,
                                        input logic [3:0] ss);
    return {tgt, op, w, ad, vv, aa, p0, mm, ss};
  endfunction

  function automatic logic [20:0] obs_of(input logic [13:0] f, input logic [AW-1:0] p,
                                         input logic b, input logic d, input logic e);
    return {f[3:0], f[4], f[5], f[6], f[9:7], f[12:10], f[13], p, b, d, e};
  endfunction

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Pops one predicted cycle per falling edge while a run is in flight; pc is ignored once idle.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t        e;
      logic [20:0] act;
      logic [20:0] mask;
      e    = expq.pop_front();
      act  = {S, M, P0, A, v, adr, wr, pc, busy, done, err};
      mask = e.chk_pc ? 21'h1FFFFF : ~21'h000078;
      sample_no++;
      check_output($sformatf("trace sample %0d", sample_no), 32'(act & mask), 32'(e.obs & mask));
    end
  end

  task automatic prog_word(input logic [AW-1:0] a, input logic [15+AW:0] d);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    model_mem[a] = d;
    @(posedge clk);
    #1 prog_we = 1'b0;
  endtask

  // p4_mode: 0 random carries, 1 all ones, 2 all zeros.
  task automatic apply_stimulus(input logic [AW-1:0] sa, input bit with_wr, input logic [AW-1:0] wa,
                                input logic [15+AW:0] wd, input bit noise, input int p4_mode);
    exp_t          tr[$];
    bit            p4s[LIMIT];
    logic [AW-1:0] cpc;
    logic [15+AW:0] w;
    logic [13:0]   f;
    bit            c, trip, abort;
    int            steps;
    for (int k = 0; k < LIMIT; k++)
      p4s[k] = (p4_mode == 1) ? 1'b1 : (p4_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    @(negedge clk);
    start      = 1'b1;
    start_addr = sa;
    if (with_wr) begin
      prog_we      = 1'b1;
      prog_addr    = wa;
      prog_data    = wd;
      model_mem[wa] = wd;
    end
    cpc = sa; c = 1'b0; steps = 0; abort = 1'b0;
    forever begin
      tr.push_back('{obs_of(14'd0, cpc, 1'b1, 1'b0, 1'b0), 1'b1});
      w = model_mem[cpc];
      steps++;
      trip = WDOG && steps == WD && w[15:14] != OP_HALT;
      f = w[13:0];
      if (trip) f[13] = 1'b0;
      tr.push_back('{obs_of(f, cpc, 1'b1, 1'b0, 1'b0), 1'b1});
      if (w[15:14] == OP_HALT || trip) begin
        tr.push_back('{obs_of(14'd0, cpc, 1'b0, 1'b1, trip), 1'b0});
        model_err = trip;
        break;
      end
      case (w[15:14])
        OP_JMP:  cpc = w[15+AW:16];
        OP_JC:   cpc = c ? w[15+AW:16] : cpc + 1'b1;
        default: cpc = cpc + 1'b1;
      endcase
      c = p4s[steps-1];
      if (steps == LIMIT) begin
        abort = 1'b1;
        break;
      end
    end
    @(posedge clk);
    foreach (tr[j]) expq.push_back(tr[j]);
    for (int j = 0; j < tr.size(); j++) begin
      bit busy_slot;
      @(negedge clk);
      busy_slot  = abort || j != tr.size() - 1;
      start      = busy_slot && noise && $urandom_range(0, 2) == 0;
      start_addr = AW'($urandom);
      prog_we    = busy_slot && noise && $urandom_range(0, 2) == 0;
      prog_addr  = AW'($urandom_range(0, 3));
      prog_data  = 20'($urandom);
      P4         = (j % 2 == 1) ? p4s[j/2] : 1'($urandom);
    end
    if (abort) begin
      start = 1'b0; prog_we = 1'b0;
      #2 reset = 1'b0;
      #1 check_output("reset mid-exec outputs", 32'({S, M, P0, A, v, adr, wr, pc, busy, done, err}), 32'd0);
      @(negedge clk);
      #2 reset = 1'b1;
      model_err = 1'b0;
      @(negedge clk);
      check_output("after reset release", 32'({pc, busy, done, err, wr, v}), 32'd0);
    end else begin
      @(negedge clk);
      start = 1'b0; prog_we = 1'b0;
      check_output("idle busy/err after run", 32'({busy, err}), 32'({1'b0, model_err}));
    end
    for (int t = 0; t < 5 && expq.size() > 0; t++) @(negedge clk);
    if (expq.size() > 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL scoreboard drain got %0d left want 0", expq.size());
      expq.delete();
    end
  endtask

  initial begin
    model_err = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    repeat (3) @(negedge clk);
    check_output("reset values", 32'({S, M, P0, A, v, adr, wr, pc, busy, done, err}), 32'd0);
    reset = 1'b1;

    // Initialise the whole store so the model and the sequencer agree on every word.
    for (int i = 0; i < 16; i++) prog_word(AW'(i), mk(OP_HALT, '0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0));

    $display("[TB] straight-line run");
    prog_word(0, mk(OP_NEXT, '0, 1'b0, 3'd0, 3'b001, 1'b1, 1'b0, 1'b0, 4'b1001));
    prog_word(1, mk(OP_HALT, '0, 1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0));
    apply_stimulus(0, 1'b0, 0, '0, 1'b0, 0);

    $display("[TB] busy protection");
    apply_stimulus(0, 1'b0, 0, '0, 1'b1, 0);
    apply_stimulus(0, 1'b0, 0, '0, 1'b0, 0);

    $display("[TB] conditional branch");
    prog_word(1, mk(OP_NEXT, '0, 1'b1, 3'd2, 3'b010, 1'b0, 1'b1, 1'b1, 4'b0110));
    prog_word(2, mk(OP_JC, 4'd7, 1'b0, 3'd1, 3'b100, 1'b0, 1'b0, 1'b0, 4'b0011));
    prog_word(3, mk(OP_HALT, '0, 1'b1, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 4'b1111));
    prog_word(7, mk(OP_HALT, '0, 1'b1, 3'd7, 3'd0, 1'b1, 1'b0, 1'b0, 4'b0001));
    apply_stimulus(1, 1'b0, 0, '0, 1'b0, 1);
    apply_stimulus(1, 1'b0, 0, '0, 1'b0, 2);

    $display("[TB] wrap and jump");
    prog_word(15, mk(OP_NEXT, '0, 1'b0, 3'd4, 3'b011, 1'b0, 1'b0, 1'b1, 4'b0101));
    prog_word(0, mk(OP_JMP, 4'd5, 1'b1, 3'd6, 3'b101, 1'b1, 1'b1, 1'b0, 4'b1100));
    prog_word(5, mk(OP_HALT, '0, 1'b0, 3'd2, 3'b110, 1'b0, 1'b0, 1'b0, 4'b1010));
    apply_stimulus(15, 1'b0, 0, '0, 1'b0, 0);

    $display("[TB] write and start in the same cycle");
    apply_stimulus(4, 1'b1, 4, mk(OP_HALT, '0, 1'b1, 3'd6, 3'b001, 1'b1, 1'b0, 1'b1, 4'b0111), 1'b0, 0);

    $display("[TB] runaway loop");
    prog_word(0, mk(OP_JMP, 4'd0, 1'b1, 3'd1, 3'b001, 1'b0, 1'b0, 1'b0, 4'b0010));
    apply_stimulus(0, 1'b0, 0, '0, 1'b0, 0);
    apply_stimulus(4, 1'b0, 0, '0, 1'b0, 0);

    $display("[TB] random programs");
    for (int r = 0; r < 25; r++) begin
      int nw;
      nw = $urandom_range(0, 4);
      for (int k = 0; k < nw; k++)
        prog_word(AW'($urandom), 20'($urandom));
      apply_stimulus(AW'($urandom), 1'($urandom_range(0, 1)), AW'($urandom), 20'($urandom), 1'b1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
